dbg_mem_master: RTL and testbench
=================================

# dbg_mem_master

Debug-side initiator for the RAM's second (debug) port. Consumes a byte-stream command protocol from the debug UART receiver, issues single-cycle read/write strobes on the `dbg_*` memory port with address auto-increment, and returns read data or acknowledgements as a byte stream to the debug UART transmitter. Sits between the UART byte links and the RAM debug port inside the debug unit, letting a host peek/poke memory independently of the CPU.

## Interface
- `TIMEOUT_CYCLES`, 1_000_000, max idle cycles between bytes of a partial command before abort (≥2)
- `clk`  in  1  system clock; also source of all memory strobes
- `rst`  in  1  synchronous, active-high reset
- `rx_data`  in  8  command byte from UART receiver
- `rx_valid`  in  1  `rx_data` valid
- `rx_ready`  out  1  block accepts `rx_data` this cycle
- `tx_data`  out  8  response byte to UART transmitter
- `tx_valid`  out  1  `tx_data` valid
- `tx_ready`  in  1  transmitter accepts `tx_data` this cycle
- `dbg_mem_op`  out  1  selects debug port in RAM
- `dbg_mem_clk`  out  1  one-`clk`-cycle memory clock pulse
- `dbg_addr`  out  16  memory address
- `dbg_data_in`  out  8  write data
- `dbg_data_out`  in  8  read data (high-Z when addr[15]=1)
- `dbg_RW`  out  1  1 = read, 0 = write
- `busy`  out  1  state ≠ IDLE

## Operation
- Command frame: opcode, addr_hi, addr_lo, len; write frames then carry len data bytes. len=0 means 256.
- Opcodes: 0x52 'R' read burst, 0x57 'W' write burst. Any other opcode in IDLE: consumed, respond 0x3F '?', stay IDLE.
- States: IDLE → ADDR_HI → ADDR_LO → LEN → (R) RD_SETUP or (W) WR_DATA.
- Write loop: WR_DATA (accept byte) → WR_SETUP (addr, data, RW=0, op=1) → WR_STROBE (mem_clk=1) → decrement count, increment addr → WR_DATA, or TX_ACK when count done. TX_ACK sends 0x4B 'K' → IDLE.
- Read loop: RD_SETUP (addr, RW=1, op=1) → RD_STROBE (mem_clk=1) → RD_CAPTURE (latch `dbg_data_out`, or 0xFF if addr[15]=1) → TX_BYTE (hold until `tx_ready`) → increment addr, decrement count → RD_SETUP, or IDLE when done. No trailing ack on reads.
- Address increments modulo 2^16 (0xFFFF → 0x0000); count held in 9 bits.
- `rx_ready`=1 only in IDLE, ADDR_HI, ADDR_LO, LEN, WR_DATA; byte consumed when `rx_valid & rx_ready`.
- `tx_valid` asserted in TX_BYTE, TX_ACK, error response; `tx_data` stable while `tx_valid & ~tx_ready`.
- Timeout: counter cleared on every consumed byte and on entering ADDR_HI; increments in ADDR_HI/ADDR_LO/LEN/WR_DATA; reaching `TIMEOUT_CYCLES` → IDLE, no response, no memory access for the partial byte.
- Writes to addr[15]=1 still strobe (RAM ignores them); ack still sent.

## Timing
- Reset values: `rx_ready`=0, `tx_valid`=0, `tx_data`=0x00, `dbg_mem_op`=0, `dbg_mem_clk`=0, `dbg_addr`=0x0000, `dbg_data_in`=0x00, `dbg_RW`=1, `busy`=0, state IDLE, counters 0.
- `rst` mid-burst: next edge aborts everything to reset values; no further strobes, partial response dropped.
- All outputs registered. `dbg_mem_clk` high exactly one cycle per access, preceded by ≥1 cycle of stable `dbg_addr`/`dbg_data_in`/`dbg_RW`/`dbg_mem_op`.
- `dbg_mem_op` high in SETUP, STROBE, and RD_CAPTURE; low elsewhere. `dbg_RW` returns to 1 outside WR_SETUP/WR_STROBE.
- Write byte: accept → strobe 2 cycles later. Read byte: RD_SETUP entry → `tx_valid` 3 cycles later.
- Simultaneous consumed byte and timeout terminal count: byte wins, counter clears.

## Structure
- Shared package `dbg_pkg`: opcode constants (0x52, 0x57), response bytes (0x4B, 0x3F), read-fill 0xFF, state enum.
- One sub-module `dbg_timeout`: loadable clear/enable counter with terminal-count flag, parameterised by `TIMEOUT_CYCLES`.

## Test plan
- Frame 57 01 00 02 AA 55, `tx_ready`=1 → strobes at 0x0100=AA, 0x0101=55 with RW=0; tx 0x4B; RAM readback matches.
- Frame 52 01 00 02 after above → tx AA then 55; `tx_valid` held stable across 5 cycles of `tx_ready`=0.
- Write 57 FF FF 02 11 22 then read 52 FF FE 03 → strobes at 0xFFFF then 0x0000; read returns FF, FF, 22 (first two from addr[15]=1 fill).
- Opcode 0x00 → tx 0x3F, no `dbg_mem_clk` pulse; following valid frame executes normally.
- `TIMEOUT_CYCLES`=16: send 57 00 10 then stall 16 cycles → back to IDLE, no strobe, no tx; next 52 frame works.
- Assert `rst` during 4-byte read burst after 2nd strobe → all outputs at reset values next cycle, no further strobes or tx.

Source files
------------

// File: rtl/dbg_pkg.sv
// Shared constants and state encoding for the debug memory master.
// Opcodes, response bytes and the read fill byte live here so the bench and the RTL agree.
package dbg_pkg;

   localparam logic [7:0] OP_RD   = 8'h52;
   localparam logic [7:0] OP_WR   = 8'h57;
   localparam logic [7:0] RSP_ACK = 8'h4B;
   localparam logic [7:0] RSP_ERR = 8'h3F;
   localparam logic [7:0] RD_FILL = 8'hFF;

   typedef enum logic [3:0] {
      S_IDLE       = 4'd0,
      S_ADDR_HI    = 4'd1,
      S_ADDR_LO    = 4'd2,
      S_LEN        = 4'd3,
      S_WR_DATA    = 4'd4,
      S_WR_SETUP   = 4'd5,
      S_WR_STROBE  = 4'd6,
      S_TX_ACK     = 4'd7,
      S_RD_SETUP   = 4'd8,
      S_RD_STROBE  = 4'd9,
      S_RD_CAPTURE = 4'd10,
      S_TX_BYTE    = 4'd11
   } state_t;

   function automatic logic is_opcode(input logic [7:0] b);
      return (b == OP_RD) || (b == OP_WR);
   endfunction

endpackage

// File: rtl/dbg_timeout.sv
// Inter-byte idle counter: cleared by the master, counts while enabled, flags the last cycle.
// The flag is raised during the TIMEOUT_CYCLES-th idle cycle so the abort lands on that edge.
module dbg_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int unsigned W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= '0;
      else if (en && !tc)
         cnt <= cnt + W'(1);
   end

   assign tc = (cnt == LAST);

endmodule

// File: rtl/dbg_mem_master.sv
// Byte-stream peek/poke master for the RAM debug port: R/W bursts with address auto-increment.
// Every output is registered from the next state, so strobes follow a full cycle of stable setup.
module dbg_mem_master
   import dbg_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        dbg_mem_op,
   output logic        dbg_mem_clk,
   output logic [15:0] dbg_addr,
   output logic [7:0]  dbg_data_in,
   input  logic [7:0]  dbg_data_out,
   output logic        dbg_RW,
   output logic        busy
);

   state_t     state, nxt;
   logic       err_pend, err_nxt;
   logic       is_rd;
   logic [8:0] cnt;
   logic       rx_fire, waiting, to_tc, last;

   assign rx_fire = rx_valid & rx_ready;
   assign waiting = state inside {S_ADDR_HI, S_ADDR_LO, S_LEN, S_WR_DATA};
   assign last    = (cnt == 9'd1);

   dbg_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk (clk),
      .rst (rst),
      .clr (rx_fire | ~waiting),
      .en  (waiting),
      .tc  (to_tc)
   );

   // An unknown opcode keeps the FSM in IDLE; err_pend holds the '?' reply until it drains.
   always_comb begin
      nxt     = state;
      err_nxt = err_pend;
      unique case (state)
         S_IDLE: begin
            if (err_pend) begin
               if (tx_ready) err_nxt = 1'b0;
            end else if (rx_fire) begin
               if (is_opcode(rx_data)) nxt = S_ADDR_HI;
               else                    err_nxt = 1'b1;
            end
         end
         S_ADDR_HI:    if (rx_fire) nxt = S_ADDR_LO; else if (to_tc) nxt = S_IDLE;
         S_ADDR_LO:    if (rx_fire) nxt = S_LEN;     else if (to_tc) nxt = S_IDLE;
         S_LEN: begin
            if (rx_fire)    nxt = is_rd ? S_RD_SETUP : S_WR_DATA;
            else if (to_tc) nxt = S_IDLE;
         end
         S_WR_DATA:    if (rx_fire) nxt = S_WR_SETUP; else if (to_tc) nxt = S_IDLE;
         S_WR_SETUP:   nxt = S_WR_STROBE;
         S_WR_STROBE:  nxt = last ? S_TX_ACK : S_WR_DATA;
         S_TX_ACK:     if (tx_ready) nxt = S_IDLE;
         S_RD_SETUP:   nxt = S_RD_STROBE;
         S_RD_STROBE:  nxt = S_RD_CAPTURE;
         S_RD_CAPTURE: nxt = S_TX_BYTE;
         S_TX_BYTE:    if (tx_ready) nxt = last ? S_IDLE : S_RD_SETUP;
         default:      nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         err_pend    <= 1'b0;
         is_rd       <= 1'b0;
         cnt         <= 9'd0;
         rx_ready    <= 1'b0;
         tx_valid    <= 1'b0;
         tx_data     <= 8'h00;
         dbg_mem_op  <= 1'b0;
         dbg_mem_clk <= 1'b0;
         dbg_addr    <= 16'h0000;
         dbg_data_in <= 8'h00;
         dbg_RW      <= 1'b1;
         busy        <= 1'b0;
      end else begin
         state       <= nxt;
         err_pend    <= err_nxt;
         rx_ready    <= (nxt inside {S_IDLE, S_ADDR_HI, S_ADDR_LO, S_LEN, S_WR_DATA}) && !err_nxt;
         tx_valid    <= (nxt inside {S_TX_BYTE, S_TX_ACK}) || err_nxt;
         dbg_mem_op  <= nxt inside {S_WR_SETUP, S_WR_STROBE, S_RD_SETUP, S_RD_STROBE, S_RD_CAPTURE};
         dbg_mem_clk <= nxt inside {S_WR_STROBE, S_RD_STROBE};
         dbg_RW      <= !(nxt inside {S_WR_SETUP, S_WR_STROBE});
         busy        <= (nxt != S_IDLE);

         if (rx_fire) begin
            unique case (state)
               S_IDLE:    is_rd <= (rx_data == OP_RD);
               S_ADDR_HI: dbg_addr[15:8] <= rx_data;
               S_ADDR_LO: dbg_addr[7:0]  <= rx_data;
               S_LEN:     cnt <= {rx_data == 8'h00, rx_data};  // len 0 means 256
               S_WR_DATA: dbg_data_in <= rx_data;
               default: ;
            endcase
         end

         // Advance after each completed access; address wraps at 16 bits.
         if ((state == S_WR_STROBE) || (state == S_TX_BYTE && tx_ready)) begin
            dbg_addr <= dbg_addr + 16'd1;
            cnt      <= cnt - 9'd1;
         end

         if (state == S_IDLE && rx_fire && !is_opcode(rx_data))
            tx_data <= RSP_ERR;
         else if (state == S_WR_STROBE && last)
            tx_data <= RSP_ACK;
         else if (state == S_RD_CAPTURE)
            tx_data <= dbg_addr[15] ? RD_FILL : dbg_data_out;
      end
   end

endmodule

// File: tb/tb_dbg_mem_master.sv
// Bench for dbg_mem_master: directed vector table, corner sequences, then random frames vs a frame-level model.
module tb_dbg_mem_master;

   localparam int unsigned TO = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b1;
   logic        dbg_mem_op, dbg_mem_clk, dbg_RW, busy;
   logic [15:0] dbg_addr;
   logic [7:0]  dbg_data_in, dbg_data_out;

   always #5 clk = ~clk;

   dbg_mem_master #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .dbg_mem_op(dbg_mem_op), .dbg_mem_clk(dbg_mem_clk), .dbg_addr(dbg_addr),
      .dbg_data_in(dbg_data_in), .dbg_data_out(dbg_data_out), .dbg_RW(dbg_RW), .busy(busy)
   );

   // RAM debug port: 32 KiB, upper half undecoded (bus returns junk there).
   logic [7:0] ram [0:32767];
   logic [7:0] rd_q = 8'h00;
   always @(posedge dbg_mem_clk) begin
      if (dbg_mem_op) begin
         if (!dbg_RW) begin
            if (!dbg_addr[15]) ram[dbg_addr[14:0]] <= dbg_data_in;
         end else
            rd_q <= ram[dbg_addr[14:0]];
      end
   end
   assign dbg_data_out = dbg_addr[15] ? 8'hA5 : rd_q;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   // tx_ready driver: 0 = always ready, 1 = random, 2 = left to the test sequence
   int tx_mode = 0;
   always @(posedge clk) begin
      #2;
      if (tx_mode == 0)      tx_ready = 1'b1;
      else if (tx_mode == 1) tx_ready = 1'($urandom_range(0, 1));
   end

   // Monitor: records strobes and tx handshakes, checks setup stability and tx hold.
   logic [7:0]  act_tx[$];
   logic [24:0] act_stb[$];
   int          n_stb = 0;
   logic        p_op = 0, p_clk = 0, p_rw = 1, p_txv = 0, p_txr = 0, p_rst = 1;
   logic [15:0] p_addr = 0;
   logic [7:0]  p_din = 0, p_txd = 0;
   always @(negedge clk) begin
      if (!rst && !p_rst) begin
         if (dbg_mem_clk) begin
            n_stb++;
            act_stb.push_back({dbg_RW, dbg_addr, dbg_RW ? 8'h00 : dbg_data_in});
            chk("strobe_setup", {p_op, p_clk, p_addr, p_rw, p_din, dbg_mem_op},
                {1'b1, 1'b0, dbg_addr, dbg_RW, dbg_data_in, 1'b1});
         end
         if (p_txv && !p_txr) chk("tx_hold", {tx_valid, tx_data}, {1'b1, p_txd});
         if (tx_valid && tx_ready) act_tx.push_back(tx_data);
      end
      p_op = dbg_mem_op; p_clk = dbg_mem_clk; p_rw = dbg_RW; p_addr = dbg_addr;
      p_din = dbg_data_in; p_txv = tx_valid; p_txr = tx_ready; p_txd = tx_data; p_rst = rst;
   end

   // Frame-level reference model
   logic [7:0]  ref_mem [0:32767];
   logic [7:0]  exp_tx[$];
   logic [24:0] exp_stb[$];
   logic [7:0]  frm[$];

   task automatic model_frame();
      logic [15:0] base, a;
      int n;
      if (frm[0] == 8'h52 || frm[0] == 8'h57) begin
         base = {frm[1], frm[2]};
         n = (frm[3] == 8'h00) ? 256 : int'(frm[3]);
         for (int i = 0; i < n; i++) begin
            a = base + 16'(i);
            if (frm[0] == 8'h57) begin
               exp_stb.push_back({1'b0, a, frm[4+i]});
               if (!a[15]) ref_mem[a[14:0]] = frm[4+i];
            end else begin
               exp_stb.push_back({1'b1, a, 8'h00});
               exp_tx.push_back(a[15] ? 8'hFF : ref_mem[a[14:0]]);
            end
         end
         if (frm[0] == 8'h57) exp_tx.push_back(8'h4B);
      end else
         exp_tx.push_back(8'h3F);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && n < 3000) begin @(negedge clk); n++; end
      if (n >= 3000) chk("rx_ready_timeout", 0, 1);
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (!(!busy && !tx_valid && rx_ready) && n < 4000) begin @(negedge clk); n++; end
      if (n >= 4000) chk("idle_timeout", 0, 1);
   endtask

   task automatic clear_q();
      act_tx.delete(); act_stb.delete(); exp_tx.delete(); exp_stb.delete();
   endtask

   task automatic run_frame();
      model_frame();
      foreach (frm[i]) send_byte(frm[i]);
      wait_idle();
   endtask

   task automatic cmp_q(input string nm);
      chk({nm, "_ntx"}, act_tx.size(), exp_tx.size());
      for (int i = 0; i < act_tx.size() && i < exp_tx.size(); i++) chk({nm, "_tx"}, act_tx[i], exp_tx[i]);
      chk({nm, "_nstb"}, act_stb.size(), exp_stb.size());
      for (int i = 0; i < act_stb.size() && i < exp_stb.size(); i++) chk({nm, "_stb"}, act_stb[i], exp_stb[i]);
   endtask

   typedef struct {
      logic [63:0] cmd;  int ncmd;
      logic [31:0] rsp;  int nrsp;
      int          nstb;
      logic [15:0] a0;   logic [15:0] a1;
   } vec_t;
   vec_t vt [7];

   localparam logic [37:0] RST_VALS = {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0};

   initial begin
      int n0, n, r;
      logic [15:0] a;
      for (int i = 0; i < 32768; i++) begin ram[i] = 8'h00; ref_mem[i] = 8'h00; end

      vt[0] = '{64'h5701_0002_AA55_0000, 6, 32'h4B00_0000, 1,   2,   16'h0100, 16'h0101};
      vt[1] = '{64'h5201_0002_0000_0000, 4, 32'hAA55_0000, 2,   2,   16'h0100, 16'h0101};
      vt[2] = '{64'h57FF_FF02_1122_0000, 6, 32'h4B00_0000, 1,   2,   16'hFFFF, 16'h0000};
      vt[3] = '{64'h52FF_FE03_0000_0000, 4, 32'hFFFF_2200, 3,   3,   16'hFFFE, 16'h0000};
      vt[4] = '{64'h0000_0000_0000_0000, 1, 32'h3F00_0000, 1,   0,   16'h0000, 16'h0000};
      vt[5] = '{64'h5201_0101_0000_0000, 4, 32'h5500_0000, 1,   1,   16'h0101, 16'h0101};
      vt[6] = '{64'h5210_0000_0000_0000, 4, 32'h0000_0000, 256, 256, 16'h1000, 16'h10FF};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_vals", {rx_ready, tx_valid, tx_data, dbg_mem_op, dbg_mem_clk, dbg_addr, dbg_data_in, dbg_RW, busy}, RST_VALS);
      @(posedge clk); #2 rst = 1'b0;

      for (int v = 0; v < 7; v++) begin
         clear_q();
         frm.delete();
         for (int i = 0; i < vt[v].ncmd; i++) frm.push_back(vt[v].cmd[63-8*i -: 8]);
         run_frame();
         chk($sformatf("vec%0d_ntx", v), act_tx.size(), vt[v].nrsp);
         for (int i = 0; i < vt[v].nrsp && i < 4; i++)
            chk($sformatf("vec%0d_tx%0d", v, i), act_tx[i], vt[v].rsp[31-8*i -: 8]);
         chk($sformatf("vec%0d_nstb", v), act_stb.size(), vt[v].nstb);
         if (vt[v].nstb > 0) begin
            chk($sformatf("vec%0d_a0", v), act_stb[0][23:8], vt[v].a0);
            chk($sformatf("vec%0d_a1", v), act_stb[$][23:8], vt[v].a1);
         end
      end

      // tx back-pressure: first read byte must sit unchanged while tx_ready is low
      clear_q();
      tx_mode = 2;
      @(posedge clk); #2 tx_ready = 1'b0;
      frm = '{8'h52, 8'h01, 8'h00, 8'h02};
      model_frame();
      foreach (frm[i]) send_byte(frm[i]);
      n = 0;
      @(negedge clk);
      while (!tx_valid && n < 20) begin @(negedge clk); n++; end
      for (int i = 0; i < 5; i++) begin
         chk("hold_tx", {tx_valid, tx_data}, {1'b1, 8'hAA});
         @(negedge clk);
      end
      @(posedge clk); #2 tx_ready = 1'b1;
      wait_idle();
      cmp_q("hold");
      tx_mode = 0;

      // partial frame abandoned: abort exactly TO cycles after the last byte
      clear_q();
      n0 = n_stb;
      send_byte(8'h57); send_byte(8'h00); send_byte(8'h10);
      repeat (TO) @(negedge clk);
      chk("to_still_busy", busy, 1'b1);
      @(negedge clk);
      chk("to_aborted", {busy, rx_ready}, 2'b01);
      chk("to_no_strobe", n_stb - n0, 0);
      chk("to_no_tx", act_tx.size(), 0);
      frm = '{8'h52, 8'h01, 8'h00, 8'h01};
      run_frame();
      cmp_q("after_to");

      // reset in the middle of a 4-byte read burst
      clear_q();
      frm = '{8'h57, 8'h02, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04};
      run_frame();
      clear_q();
      n0 = n_stb;
      foreach (frm[i]) if (i < 4) send_byte(i == 0 ? 8'h52 : frm[i]);
      n = 0;
      @(negedge clk); #1;
      while (n_stb - n0 < 2 && n < 50) begin @(negedge clk); #1; n++; end
      chk("rst_reach_2nd", n_stb - n0, 2);
      @(posedge clk); #2 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_mid_vals", {rx_ready, tx_valid, tx_data, dbg_mem_op, dbg_mem_clk, dbg_addr, dbg_data_in, dbg_RW, busy}, RST_VALS);
      @(posedge clk); #2 rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("rst_no_more_stb", n_stb - n0, 2);
      chk("rst_ntx", act_tx.size(), 1);
      chk("rst_tx0", act_tx[0], 8'h01);
      chk("rst_idle", {busy, rx_ready}, 2'b01);

      // random frames against the model, random tx back-pressure
      tx_mode = 1;
      for (int f = 0; f < 25; f++) begin
         clear_q();
         frm.delete();
         r = $urandom_range(0, 9);
         if (r < 8) begin
            r = $urandom_range(0, 3);
            a = (r == 0) ? 16'h7FFE : (r == 1) ? 16'hFFFD : 16'($urandom_range(0, 65535));
            frm.push_back((f % 2 == 0) ? 8'h57 : 8'h52);
            frm.push_back(a[15:8]);
            frm.push_back(a[7:0]);
            n = ($urandom_range(0, 11) == 0) ? 0 : $urandom_range(1, 6);
            frm.push_back(8'(n));
            if (frm[0] == 8'h57)
               for (int i = 0; i < ((n == 0) ? 256 : n); i++) frm.push_back(8'($urandom_range(0, 255)));
         end else begin
            r = $urandom_range(0, 255);
            frm.push_back((r == 'h52 || r == 'h57) ? 8'h00 : 8'(r));
         end
         run_frame();
         cmp_q($sformatf("rnd%0d", f));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #900_000;
      $display("FAIL watchdog got=running want=finished");
      $fatal(1, "watchdog");
   end

endmodule
